// File: rtl/cpu_pipe_pkg.sv
// Shared execute->writeback pipeline types: default widths, the X->WB entry payload
// and the skid-stage occupancy encoding.
package cpu_pipe_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LANES      = 4;
    localparam int DEF_REG_ADDR_W = 4;
    localparam int DEF_PC_W       = 16;

    typedef struct packed {
        logic [DEF_PC_W-1:0]              pc;
        logic [DEF_REG_ADDR_W-1:0]        rt;
        logic                             wen_s;
        logic                             wen_v;
        logic [DEF_DATA_W-1:0]            sdata;
        logic [DEF_LANES*DEF_DATA_W-1:0]  vdata;
        logic [DEF_LANES-1:0]             lane_mask;
        logic                             is_halt;
    } x2wb_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/exec_wb_skid_stage_entry_reg.sv
// One buffered pipeline entry: a valid bit plus payload. Load wins over clear;
// clearing only drops valid so the payload stays quiet while idle.
module pipe_entry_reg #(
    parameter type T = cpu_pipe_pkg::x2wb_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  T     d,
    output logic valid,
    output T     q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_wb_skid_stage.sv
// Execute->writeback stage: 2-entry skid buffer (MAIN drives outputs, SKID absorbs one
// extra push) so WB back-pressure only reaches execute through the registered in_ready.
module exec_wb_skid_stage
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LANES      = DEF_LANES,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int PC_W       = DEF_PC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [REG_ADDR_W-1:0]   in_rt,
    input  logic                    in_wen_s,
    input  logic                    in_wen_v,
    input  logic [DATA_W-1:0]       in_sdata,
    input  logic [LANES*DATA_W-1:0] in_vdata,
    input  logic [LANES-1:0]        in_lane_mask,
    input  logic                    in_is_halt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [REG_ADDR_W-1:0]   out_rt,
    output logic                    out_wen_s,
    output logic                    out_wen_v,
    output logic [DATA_W-1:0]       out_sdata,
    output logic [LANES*DATA_W-1:0] out_vdata,
    output logic [LANES-1:0]        out_lane_mask,
    output logic                    out_is_halt,
    output logic                    fwd_valid,
    output logic [REG_ADDR_W-1:0]   fwd_rt,
    output logic [DATA_W-1:0]       fwd_sdata,
    output logic                    halted
);

    // Local payload type so non-default widths stay consistent with the ports.
    typedef struct packed {
        logic [PC_W-1:0]         pc;
        logic [REG_ADDR_W-1:0]   rt;
        logic                    wen_s;
        logic                    wen_v;
        logic [DATA_W-1:0]       sdata;
        logic [LANES*DATA_W-1:0] vdata;
        logic [LANES-1:0]        lane_mask;
        logic                    is_halt;
    } entry_t;

    occ_state_e state, stateNext;
    entry_t     inEntry, mainD, mainQ, skidQ;
    logic       mainValid, skidValid;
    logic       mainLoad, mainClear, skidLoad, skidClear;
    logic       inReadyQ, inReadyNext;
    logic       haltPending, haltPendingNext;
    logic       haltedQ, haltedNext;
    logic       push, pop;

    assign push = in_valid & inReadyQ;
    assign pop  = mainValid & out_ready;

    // A vector write with no enabled lanes is squashed at capture.
    assign inEntry = '{pc: in_pc, rt: in_rt, wen_s: in_wen_s,
                       wen_v: in_wen_v & (|in_lane_mask), sdata: in_sdata,
                       vdata: in_vdata, lane_mask: in_lane_mask, is_halt: in_is_halt};

    assign mainD = skidValid ? skidQ : inEntry;

    pipe_entry_reg #(.T(entry_t)) u_main (
        .clk(clk), .rst_n(rst_n), .load(mainLoad), .clear(mainClear),
        .d(mainD), .valid(mainValid), .q(mainQ)
    );

    pipe_entry_reg #(.T(entry_t)) u_skid (
        .clk(clk), .rst_n(rst_n), .load(skidLoad), .clear(skidClear),
        .d(inEntry), .valid(skidValid), .q(skidQ)
    );

    always_comb begin
        stateNext = state;
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        if (flush) begin
            stateNext = OCC_EMPTY;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: if (push) begin
                    stateNext = OCC_ONE;
                    mainLoad  = 1'b1;
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        stateNext = OCC_TWO;
                        skidLoad  = 1'b1;
                    end else if (push && pop) begin
                        mainLoad  = 1'b1;
                    end else if (pop) begin
                        stateNext = OCC_EMPTY;
                        mainClear = 1'b1;
                    end
                end
                OCC_TWO: if (pop) begin
                    stateNext = OCC_ONE;
                    mainLoad  = 1'b1;
                    skidClear = 1'b1;
                end
                default: stateNext = OCC_EMPTY;
            endcase
        end
    end

    // A HALT consumed by WB retires even when a flush lands on the same edge.
    always_comb begin
        haltedNext = haltedQ | (pop & mainQ.is_halt);
        haltPendingNext = haltPending;
        if (flush)
            haltPendingNext = 1'b0;
        else if (push && in_is_halt)
            haltPendingNext = 1'b1;
        else if (pop && mainQ.is_halt)
            haltPendingNext = 1'b0;
        inReadyNext = (stateNext != OCC_TWO) & ~haltPendingNext & ~haltedNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OCC_EMPTY;
            inReadyQ    <= 1'b1;
            haltPending <= 1'b0;
            haltedQ     <= 1'b0;
        end else begin
            state       <= stateNext;
            inReadyQ    <= inReadyNext;
            haltPending <= haltPendingNext;
            haltedQ     <= haltedNext;
        end
    end

    assign in_ready      = inReadyQ;
    assign halted        = haltedQ;
    assign out_valid     = mainValid;
    assign out_pc        = mainQ.pc;
    assign out_rt        = mainQ.rt;
    assign out_wen_s     = mainQ.wen_s;
    assign out_wen_v     = mainQ.wen_v;
    assign out_sdata     = mainQ.sdata;
    assign out_lane_mask = mainQ.lane_mask;
    assign out_is_halt   = mainQ.is_halt;
    assign fwd_valid     = mainValid & mainQ.wen_s;
    assign fwd_rt        = mainQ.rt;
    assign fwd_sdata     = mainQ.sdata;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign out_vdata[l*DATA_W +: DATA_W] =
            mainQ.lane_mask[l] ? mainQ.vdata[l*DATA_W +: DATA_W] : '0;
    end

endmodule

// File: tb/tb_exec_wb_skid_stage.sv
// Randomised + directed bench for exec_wb_skid_stage against a queue-based model.
module tb_exec_wb_skid_stage;

    localparam int DW = 16, LN = 4, AW = 4, PW = 16;

    logic               clk, rst_n, flush;
    logic               in_valid, in_ready;
    logic [PW-1:0]      in_pc;
    logic [AW-1:0]      in_rt;
    logic               in_wen_s, in_wen_v;
    logic [DW-1:0]      in_sdata;
    logic [LN*DW-1:0]   in_vdata;
    logic [LN-1:0]      in_lane_mask;
    logic               in_is_halt;
    logic               out_valid, out_ready;
    logic [PW-1:0]      out_pc;
    logic [AW-1:0]      out_rt;
    logic               out_wen_s, out_wen_v;
    logic [DW-1:0]      out_sdata;
    logic [LN*DW-1:0]   out_vdata;
    logic [LN-1:0]      out_lane_mask;
    logic               out_is_halt;
    logic               fwd_valid;
    logic [AW-1:0]      fwd_rt;
    logic [DW-1:0]      fwd_sdata;
    logic               halted;

    exec_wb_skid_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rt(in_rt),
        .in_wen_s(in_wen_s), .in_wen_v(in_wen_v), .in_sdata(in_sdata),
        .in_vdata(in_vdata), .in_lane_mask(in_lane_mask), .in_is_halt(in_is_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rt(out_rt),
        .out_wen_s(out_wen_s), .out_wen_v(out_wen_v), .out_sdata(out_sdata),
        .out_vdata(out_vdata), .out_lane_mask(out_lane_mask), .out_is_halt(out_is_halt),
        .fwd_valid(fwd_valid), .fwd_rt(fwd_rt), .fwd_sdata(fwd_sdata), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]    pc;
        logic [AW-1:0]    rt;
        logic             ws, wv;
        logic [DW-1:0]    sd;
        logic [LN*DW-1:0] vd;
        logic [LN-1:0]    mask;
        logic             halt;
    } ent_t;

    int   nCmp = 0, nErr = 0;
    ent_t mq[$];
    logic mReady = 1'b1, mHp = 1'b0, mHalted = 1'b0;
    logic seen30 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [LN*DW-1:0] maskLanes(input logic [LN*DW-1:0] vd, input logic [LN-1:0] m);
        logic [LN*DW-1:0] r;
        r = '0;
        for (int l = 0; l < LN; l++)
            if (m[l]) r[l*DW +: DW] = vd[l*DW +: DW];
        return r;
    endfunction

    // Model: a FIFO of at most two entries plus two halt flags.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mReady  = 1'b1;
            mHp     = 1'b0;
            mHalted = 1'b0;
        end else begin
            logic doPush, doPop;
            ent_t ne;
            doPush = in_valid && mReady;
            doPop  = (mq.size() > 0) && out_ready;
            if (doPop && mq[0].halt) mHalted = 1'b1;
            if (flush) begin
                mq.delete();
                mHp = 1'b0;
            end else begin
                if (doPop) begin
                    if (mq[0].halt) mHp = 1'b0;
                    mq.delete(0);
                end
                if (doPush) begin
                    ne.pc = in_pc; ne.rt = in_rt; ne.ws = in_wen_s;
                    ne.wv = in_wen_v && (in_lane_mask != 0);
                    ne.sd = in_sdata; ne.vd = in_vdata; ne.mask = in_lane_mask;
                    ne.halt = in_is_halt;
                    mq.push_back(ne);
                    if (in_is_halt) mHp = 1'b1;
                end
            end
            mReady = (mq.size() < 2) && !mHp && !mHalted;
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (out_valid && out_pc == 16'h0030) seen30 = 1'b1;
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mReady));
        chk("halted", 64'(halted), 64'(mHalted));
        if (mq.size() > 0) begin
            e = mq[0];
            chk("out_pc", 64'(out_pc), 64'(e.pc));
            chk("out_rt", 64'(out_rt), 64'(e.rt));
            chk("out_wen_s", 64'(out_wen_s), 64'(e.ws));
            chk("out_wen_v", 64'(out_wen_v), 64'(e.wv));
            chk("out_sdata", 64'(out_sdata), 64'(e.sd));
            chk("out_vdata", 64'(out_vdata), 64'(maskLanes(e.vd, e.mask)));
            chk("out_lane_mask", 64'(out_lane_mask), 64'(e.mask));
            chk("out_is_halt", 64'(out_is_halt), 64'(e.halt));
            chk("fwd_valid", 64'(fwd_valid), 64'(e.ws));
            chk("fwd_rt", 64'(fwd_rt), 64'(e.rt));
            chk("fwd_sdata", 64'(fwd_sdata), 64'(e.sd));
        end else begin
            chk("fwd_valid_idle", 64'(fwd_valid), 64'd0);
        end
    end

    task automatic setIn(input logic v, input logic [PW-1:0] pc, input logic ws, input logic wv,
                         input logic [LN*DW-1:0] vd, input logic [LN-1:0] m, input logic h);
        in_valid = v; in_pc = pc; in_rt = pc[AW-1:0]; in_wen_s = ws; in_wen_v = wv;
        in_sdata = pc ^ 16'hA5A5; in_vdata = vd; in_lane_mask = m; in_is_halt = h;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic midReset();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_halted", 64'(halted), 64'd0);
        chk("arst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pcn;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        setIn(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_vdata", 64'(out_vdata), 64'd0);
        chk("rst_out_sdata", 64'(out_sdata), 64'd0);
        rst_n = 1'b1;

        // back-to-back stream
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            setIn(1'b1, PW'(16'h0010 + i), 1'b1, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            chk("stream_pc", 64'(out_pc), 64'(16'h0010 + i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        idle();
        @(negedge clk);

        // back-pressure
        out_ready = 1'b0;
        setIn(1'b1, 16'h0020, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        setIn(1'b1, 16'h0021, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        idle();
        @(negedge clk);
        chk("bp_hold_pc", 64'(out_pc), 64'h20);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_pc", 64'(out_pc), 64'h21);
        @(negedge clk);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // flush in TWO with a simultaneous push attempt
        out_ready = 1'b0;
        setIn(1'b1, 16'h0031, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        setIn(1'b1, 16'h0032, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        setIn(1'b1, 16'h0030, 1'b0, 1'b0, '0, '0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);

        // vector lane masking and capture squash
        out_ready = 1'b1;
        setIn(1'b1, 16'h0050, 1'b0, 1'b1, 64'h4444_3333_2222_1111, 4'b0101, 1'b0);
        @(negedge clk);
        chk("vec_masked", 64'(out_vdata), 64'h0000_3333_0000_1111);
        chk("vec_wen_v", 64'(out_wen_v), 64'd1);
        setIn(1'b1, 16'h0051, 1'b0, 1'b1, 64'h4444_3333_2222_1111, 4'b0000, 1'b0);
        @(negedge clk);
        chk("vec_squash", 64'(out_wen_v), 64'd0);
        chk("vec_zero", 64'(out_vdata), 64'd0);
        idle();
        @(negedge clk);

        // halt: blocks pushes, retires sticky through flush
        out_ready = 1'b0;
        setIn(1'b1, 16'h0040, 1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("halt_block", 64'(in_ready), 64'd0);
        setIn(1'b1, 16'h0041, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("halt_pc", 64'(out_pc), 64'h40);
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        chk("halted_set", 64'(halted), 64'd1);
        chk("halt_popped", 64'(out_valid), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("halted_sticky", 64'(halted), 64'd1);
        midReset();

        // randomised traffic
        pcn = 0;
        for (int c = 0; c < 3000; c++) begin
            if (mHalted && $urandom_range(0, 3) == 0) midReset();
            setIn($urandom_range(0, 9) < 7, PW'(16'h0100 + pcn), 1'($urandom),
                  1'($urandom), {$urandom, $urandom},
                  ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom),
                  $urandom_range(0, 49) == 0);
            in_rt = 4'($urandom);
            in_sdata = 16'($urandom);
            pcn++;
            flush = $urandom_range(0, 29) == 0;
            out_ready = $urandom_range(0, 9) < 6;
            @(negedge clk);
        end
        idle();
        flush = 1'b0;
        @(negedge clk);
        chk("flushed_pc_never_seen", 64'(seen30), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
